// File: rtl/sbox_ui_pkg.sv
// Shared definitions for the S-box byte entry UI.
// Holds the state codes, the nibble width, the blink terminal count and the nibble step helper.
package sbox_ui_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_EDIT_HI = 2'd0,
    ST_EDIT_LO = 2'd1,
    ST_SHOW    = 2'd2
  } state_e;

  function automatic int unsigned blink_tc(input int unsigned ms, input int unsigned mhz);
    return ms * mhz * 1000 - 1;
  endfunction

  // Opposing inc and dec cancel, so the nibble only moves when exactly one is set.
  function automatic logic [NIB_W-1:0] nib_step(input logic [NIB_W-1:0] n,
                                                input logic up, input logic dn);
    if (up && !dn) return n + 1'b1;
    if (dn && !up) return n - 1'b1;
    return n;
  endfunction

endpackage

// File: rtl/sbox_byte_entry_if.sv
// Button levels in, entered byte and display controls out.
interface sbox_byte_entry_if;
  import sbox_ui_pkg::*;

  logic                 btn_inc;
  logic                 btn_dec;
  logic                 btn_sel;
  logic [2*NIB_W-1:0]   byte_out;
  logic                 byte_valid;
  logic [1:0]           nib_en;
  logic [1:0]           state_out;

  modport master (
    output btn_inc, btn_dec, btn_sel,
    input  byte_out, byte_valid, nib_en, state_out
  );

  modport slave (
    input  btn_inc, btn_dec, btn_sel,
    output byte_out, byte_valid, nib_en, state_out
  );

endinterface

// File: rtl/edge_rise.sv
// Single-bit rising-edge detector; history resets high so a level held through reset gives no event.
module edge_rise (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lvl_i,
  output logic rise_o
);

  logic lvl_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) lvl_q <= 1'b1;
    else       lvl_q <= lvl_i;
  end

  assign rise_o = lvl_i & ~lvl_q;

endmodule

// File: rtl/sbox_byte_entry.sv
// Nibble-at-a-time byte entry: edit high, edit low, show; blinks the nibble under edit.
// Button events take effect on registered outputs one cycle after the rising edge.
module sbox_byte_entry
  import sbox_ui_pkg::*;
#(
  parameter int unsigned BLINK_MS     = 250,
  parameter int unsigned CLK_FREQ_MHZ = 50
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  sbox_byte_entry_if.slave  bus
);

  localparam int unsigned TC   = blink_tc(BLINK_MS, CLK_FREQ_MHZ);
  localparam int          CW   = (TC > 0) ? $clog2(TC + 1) : 1;
  localparam logic [CW-1:0] TC_V = CW'(TC);

  logic inc_ev, dec_ev, sel_ev;

  edge_rise u_inc (.clk_i(clk_50MHz), .rst_i(rst), .lvl_i(bus.btn_inc), .rise_o(inc_ev));
  edge_rise u_dec (.clk_i(clk_50MHz), .rst_i(rst), .lvl_i(bus.btn_dec), .rise_o(dec_ev));
  edge_rise u_sel (.clk_i(clk_50MHz), .rst_i(rst), .lvl_i(bus.btn_sel), .rise_o(sel_ev));

  state_e           state_q, state_d;
  logic [NIB_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             valid_q, valid_d;
  logic [1:0]       nib_en_q, nib_en_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             accept;

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q  <= ST_EDIT_HI;
      hi_q     <= '0;
      lo_q     <= '0;
      valid_q  <= 1'b0;
      nib_en_q <= 2'b11;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      valid_q  <= valid_d;
      nib_en_q <= nib_en_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
    end
  end

  // sel wins over inc/dec; inc/dec in SHOW are not accepted and leave the blink alone.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_EDIT_HI: begin
        if (sel_ev) begin
          state_d = ST_EDIT_LO;
          accept  = 1'b1;
        end else if (inc_ev || dec_ev) begin
          hi_d   = nib_step(hi_q, inc_ev, dec_ev);
          accept = 1'b1;
        end
      end
      ST_EDIT_LO: begin
        if (sel_ev) begin
          state_d = ST_SHOW;
          valid_d = 1'b1;
          accept  = 1'b1;
        end else if (inc_ev || dec_ev) begin
          lo_d   = nib_step(lo_q, inc_ev, dec_ev);
          accept = 1'b1;
        end
      end
      ST_SHOW: begin
        if (sel_ev) begin
          state_d = ST_EDIT_HI;
          accept  = 1'b1;
        end
      end
      default: state_d = ST_EDIT_HI;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (accept) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == TC_V) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Enables are derived from next-state values so they line up with the registered byte.
  always_comb begin
    nib_en_d = 2'b11;
    case (state_d)
      ST_EDIT_HI: nib_en_d = {phase_d, 1'b1};
      ST_EDIT_LO: nib_en_d = {1'b1, phase_d};
      default:    nib_en_d = 2'b11;
    endcase
  end

  assign bus.byte_out   = {hi_q, lo_q};
  assign bus.byte_valid = valid_q;
  assign bus.nib_en     = nib_en_q;
  assign bus.state_out  = state_q;

endmodule
